// File: rtl/br_pred_ctrl.sv
// br_pred_ctrl: branch prediction and resolution controller for a 5-stage
// RV32I pipeline.
//
// IF side : combinational lookup of a direct-mapped BHT/BTB (valid, tag,
//           target, 2-bit saturating counter) indexed by pc[IDX_W+1:2].
// EX side : selects comparator signedness, converts less/equal flags into
//           the actual outcome, flags mispredictions (flush + redirect),
//           updates the table and keeps saturating statistics counters.
//
// Handshake: an EX instruction is consumed ("resolves") in the single cycle
// where i_ex_valid=1 and i_stall=0; while stalled it is held and ignored, so
// each instruction resolves exactly once.
//
// Ports:
//   i_clk, i_reset           clock, synchronous active-high reset
//   i_if_pc                  fetch PC
//   o_pred_taken/_target     IF prediction
//   i_ex_*                   EX instruction info and carried prediction
//   o_br_un                  comparator select (1 = signed, 0 = unsigned)
//   i_br_less, i_br_equal    comparator flags
//   o_flush, o_redirect_pc   mispredict flush and corrected next PC
//   o_br_cnt, o_mispred_cnt  resolved / mispredicted counts (saturating)
module br_pred_ctrl #(
  parameter int IDX_W = 6,
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [31:0]      i_if_pc,
  output logic             o_pred_taken,
  output logic [31:0]      o_pred_target,
  input  logic             i_ex_valid,
  input  logic             i_stall,
  input  logic             i_ex_is_br,
  input  logic             i_ex_is_jmp,
  input  logic [2:0]       i_ex_funct3,
  input  logic [31:0]      i_ex_pc,
  input  logic [31:0]      i_ex_target,
  input  logic             i_ex_pred_taken,
  input  logic [31:0]      i_ex_pred_target,
  output logic             o_br_un,
  input  logic             i_br_less,
  input  logic             i_br_equal,
  output logic             o_flush,
  output logic [31:0]      o_redirect_pc,
  output logic [CNT_W-1:0] o_br_cnt,
  output logic [CNT_W-1:0] o_mispred_cnt
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = 32 - IDX_W - 2;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];

  logic [CNT_W-1:0]   br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0]   mis_cnt_q, mis_cnt_d;

  // Low PC bits are always word aligned and never take part in the lookup.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{i_if_pc[1:0], i_ex_pc[1:0]};

  // ---------------- IF lookup ----------------
  logic [IDX_W-1:0] if_idx;
  logic             if_hit;

  assign if_idx        = i_if_pc[IDX_W+1:2];
  assign if_hit        = valid_q[if_idx] && (tag_q[if_idx] == i_if_pc[31:IDX_W+2]);
  assign o_pred_taken  = if_hit && ctr_q[if_idx][1];
  assign o_pred_target = o_pred_taken ? target_q[if_idx] : i_if_pc + 32'd4;

  // ---------------- EX resolve ----------------
  logic             act;
  logic             f3_legal;
  logic             resolve;
  logic             mispred;
  logic [IDX_W-1:0] ex_idx;
  logic             ex_hit;
  logic [1:0]       ctr_d;

  assign o_br_un = ~i_ex_funct3[1];

  always_comb begin
    act      = 1'b0;
    f3_legal = 1'b1;
    case (i_ex_funct3)
      3'b000:         act = i_br_equal;
      3'b001:         act = ~i_br_equal;
      3'b100, 3'b110: act = i_br_less;
      3'b101, 3'b111: act = ~i_br_less;
      default:        f3_legal = 1'b0;
    endcase
    // Jumps are always taken; funct3 carries no branch meaning for them.
    if (i_ex_is_jmp) begin
      act      = 1'b1;
      f3_legal = 1'b1;
    end
  end

  assign resolve = i_ex_valid && !i_stall && !i_reset &&
                   (i_ex_is_br || i_ex_is_jmp) && f3_legal;
  assign mispred = resolve && ((act != i_ex_pred_taken) ||
                               (act && (i_ex_target != i_ex_pred_target)));

  assign o_flush       = mispred;
  assign o_redirect_pc = act ? i_ex_target : i_ex_pc + 32'd4;

  assign ex_idx = i_ex_pc[IDX_W+1:2];
  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == i_ex_pc[31:IDX_W+2]);

  // Saturating counter step for a hit on a conditional branch.
  always_comb begin
    ctr_d = ctr_q[ex_idx];
    if (act) begin
      if (ctr_q[ex_idx] != 2'b11) ctr_d = ctr_q[ex_idx] + 2'd1;
    end else begin
      if (ctr_q[ex_idx] != 2'b00) ctr_d = ctr_q[ex_idx] - 2'd1;
    end
  end

  always_comb begin
    br_cnt_d  = br_cnt_q;
    mis_cnt_d = mis_cnt_q;
    if (resolve && (br_cnt_q != {CNT_W{1'b1}}))  br_cnt_d  = br_cnt_q + CNT_W'(1);
    if (mispred && (mis_cnt_q != {CNT_W{1'b1}})) mis_cnt_d = mis_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      valid_q   <= '0;
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'b01;
    end else begin
      br_cnt_q  <= br_cnt_d;
      mis_cnt_q <= mis_cnt_d;
      if (resolve) begin
        if (ex_hit) begin
          if (i_ex_is_jmp) begin
            ctr_q[ex_idx]    <= 2'b11;
            target_q[ex_idx] <= i_ex_target;
          end else begin
            ctr_q[ex_idx] <= ctr_d;
            if (act) target_q[ex_idx] <= i_ex_target;
          end
        end else if (act) begin
          // Miss on a taken branch/jump: overwrite whatever owns the slot.
          valid_q[ex_idx]  <= 1'b1;
          tag_q[ex_idx]    <= i_ex_pc[31:IDX_W+2];
          target_q[ex_idx] <= i_ex_target;
          ctr_q[ex_idx]    <= i_ex_is_jmp ? 2'b11 : 2'b10;
        end
      end
    end
  end

  assign o_br_cnt      = br_cnt_q;
  assign o_mispred_cnt = mis_cnt_q;

endmodule

// File: tb/tb_br_pred_ctrl.sv
// Directed testbench for br_pred_ctrl. The driver applies one vector per
// cycle and pushes the expected output values for that cycle into exp_q;
// a monitor on the falling edge pops and compares them.
// Counters are instantiated 4 bits wide so saturation is reachable.
module tb_br_pred_ctrl;

  localparam int IDX_W = 6;
  localparam int CNT_W = 4;

  localparam int S_PT  = 0;
  localparam int S_PTG = 1;
  localparam int S_UN  = 2;
  localparam int S_FL  = 3;
  localparam int S_RD  = 4;
  localparam int S_BC  = 5;
  localparam int S_MC  = 6;

  logic             clk;
  logic             reset;
  logic [31:0]      if_pc;
  logic             pred_taken;
  logic [31:0]      pred_target;
  logic             ex_valid, stall, is_br, is_jmp;
  logic [2:0]       funct3;
  logic [31:0]      ex_pc, ex_target, ex_pred_target;
  logic             ex_pred_taken;
  logic             br_un, less, equal, flush;
  logic [31:0]      redirect_pc;
  logic [CNT_W-1:0] br_cnt, mis_cnt;

  br_pred_ctrl #(.IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .i_clk            (clk),
    .i_reset          (reset),
    .i_if_pc          (if_pc),
    .o_pred_taken     (pred_taken),
    .o_pred_target    (pred_target),
    .i_ex_valid       (ex_valid),
    .i_stall          (stall),
    .i_ex_is_br       (is_br),
    .i_ex_is_jmp      (is_jmp),
    .i_ex_funct3      (funct3),
    .i_ex_pc          (ex_pc),
    .i_ex_target      (ex_target),
    .i_ex_pred_taken  (ex_pred_taken),
    .i_ex_pred_target (ex_pred_target),
    .o_br_un          (br_un),
    .i_br_less        (less),
    .i_br_equal       (equal),
    .o_flush          (flush),
    .o_redirect_pc    (redirect_pc),
    .o_br_cnt         (br_cnt),
    .o_mispred_cnt    (mis_cnt)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [31:0] get_out(input int sel);
    case (sel)
      S_PT:    return {31'd0, pred_taken};
      S_PTG:   return pred_target;
      S_UN:    return {31'd0, br_un};
      S_FL:    return {31'd0, flush};
      S_RD:    return redirect_pc;
      S_BC:    return {{(32-CNT_W){1'b0}}, br_cnt};
      default: return {{(32-CNT_W){1'b0}}, mis_cnt};
    endcase
  endfunction

  function automatic string sel_name(input int sel);
    case (sel)
      S_PT:    return "pred_taken";
      S_PTG:   return "pred_target";
      S_UN:    return "br_un";
      S_FL:    return "flush";
      S_RD:    return "redirect_pc";
      S_BC:    return "br_cnt";
      default: return "mispred_cnt";
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] got;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e   = exp_q.pop_front();
      got = get_out(e.sel);
      total++;
      if (e.cyc != cyc || got !== e.val) begin
        bad++;
        $display("FAIL %s cyc=%0d (checked at %0d) got=%h want=%h",
                 sel_name(e.sel), e.cyc, cyc, got, e.val);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input int sel, input logic [31:0] v);
    exp_t e;
    e.cyc = cyc;
    e.sel = sel;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [31:0] pc);
    if_pc          = pc;
    ex_valid       = 1'b0;
    stall          = 1'b0;
    is_br          = 1'b0;
    is_jmp         = 1'b0;
    funct3         = 3'b000;
    ex_pc          = 32'h0;
    ex_target      = 32'h0;
    ex_pred_taken  = 1'b0;
    ex_pred_target = 32'h0;
    less           = 1'b0;
    equal          = 1'b0;
  endtask

  // Conditional branch in EX.
  task automatic br(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] tgt,
                    input logic pt, input logic [31:0] ptgt, input logic ls, input logic eq);
    ex_valid       = 1'b1;
    stall          = 1'b0;
    is_br          = 1'b1;
    is_jmp         = 1'b0;
    funct3         = f3;
    ex_pc          = pc;
    ex_target      = tgt;
    ex_pred_taken  = pt;
    ex_pred_target = ptgt;
    less           = ls;
    equal          = eq;
  endtask

  // Jump in EX (funct3 given to show it is ignored).
  task automatic jmp(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] tgt,
                     input logic pt, input logic [31:0] ptgt);
    br(f3, pc, tgt, pt, ptgt, 1'b0, 1'b0);
    is_br  = 1'b0;
    is_jmp = 1'b1;
  endtask

  // Check IF prediction and both counters in an idle cycle.
  task automatic look(input logic [31:0] pc, input logic pt, input logic [31:0] ptg,
                      input int bc, input int mc);
    idle(pc);
    chk(S_PT, {31'd0, pt});
    chk(S_PTG, ptg);
    chk(S_BC, bc);
    chk(S_MC, mc);
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle(32'h100);
    reset = 1'b1;
    tick();
    chk(S_FL, 0);
    tick();
    reset = 1'b0;

    // 1: empty table
    look(32'h100, 0, 32'h104, 0, 0);

    // 2: BEQ taken, predicted not taken -> allocate ctr 10
    br(3'b000, 32'h100, 32'h80, 0, 32'h104, 0, 1);
    chk(S_UN, 1); chk(S_FL, 1); chk(S_RD, 32'h80);
    chk(S_PT, 0);                       // same-cycle write not visible
    tick();
    look(32'h100, 1, 32'h80, 1, 1);

    // 3: BLTU not taken, miss -> no allocation (0x200 aliases index 0)
    br(3'b110, 32'h200, 32'h180, 0, 32'h204, 0, 0);
    chk(S_UN, 0); chk(S_FL, 0); chk(S_RD, 32'h204);
    tick();
    look(32'h200, 0, 32'h204, 2, 1);
    look(32'h100, 1, 32'h80, 2, 1);
    br(3'b110, 32'h200, 32'h180, 0, 32'h204, 1, 0);
    chk(S_FL, 1); chk(S_RD, 32'h180);
    tick();
    look(32'h200, 1, 32'h180, 3, 2);
    look(32'h100, 0, 32'h104, 3, 2);    // evicted by 0x200

    // 4: BNE loop at 0x100: alloc(10), 11, 11
    br(3'b001, 32'h100, 32'h80, 0, 32'h104, 0, 0);
    chk(S_FL, 1); chk(S_RD, 32'h80);
    tick();
    for (int i = 0; i < 2; i++) begin
      br(3'b001, 32'h100, 32'h80, 1, 32'h80, 0, 0);
      chk(S_FL, 0);
      tick();
    end
    look(32'h100, 1, 32'h80, 6, 3);
    br(3'b001, 32'h100, 32'h80, 1, 32'h80, 0, 1);   // not taken: 11 -> 10
    chk(S_FL, 1); chk(S_RD, 32'h104);
    tick();
    look(32'h100, 1, 32'h80, 7, 4);
    br(3'b001, 32'h100, 32'h80, 1, 32'h80, 0, 1);   // 10 -> 01
    chk(S_FL, 1); chk(S_RD, 32'h104);
    tick();
    look(32'h100, 0, 32'h104, 8, 5);

    // 5: JAL, wrong predicted target; funct3 010 ignored for jumps
    jmp(3'b010, 32'h300, 32'h400, 1, 32'h500);
    chk(S_UN, 0); chk(S_FL, 1); chk(S_RD, 32'h400);
    tick();
    look(32'h300, 1, 32'h400, 9, 6);
    jmp(3'b010, 32'h300, 32'h400, 1, 32'h400);
    chk(S_FL, 0);
    tick();
    jmp(3'b000, 32'h300, 32'h440, 1, 32'h400);      // hit, target changes
    chk(S_FL, 1); chk(S_RD, 32'h440);
    tick();
    look(32'h300, 1, 32'h440, 11, 7);

    // illegal funct3 branch: no flush, no count, no update
    br(3'b011, 32'h500, 32'h600, 1, 32'h600, 1, 1);
    chk(S_UN, 0); chk(S_FL, 0);
    tick();
    look(32'h300, 1, 32'h440, 11, 7);

    // bubble carrying a would-be mispredict
    br(3'b101, 32'h300, 32'h80, 1, 32'h440, 0, 0);
    ex_valid = 1'b0;
    chk(S_UN, 1); chk(S_FL, 0);
    tick();
    look(32'h300, 1, 32'h440, 11, 7);

    // 6: stall for 3 cycles, then release (BGE at 0x104, index 1)
    for (int i = 0; i < 3; i++) begin
      br(3'b101, 32'h104, 32'h40, 0, 32'h108, 0, 0);
      stall = 1'b1;
      chk(S_FL, 0); chk(S_BC, 11);
      tick();
    end
    br(3'b101, 32'h104, 32'h40, 0, 32'h108, 0, 0);
    chk(S_FL, 1); chk(S_RD, 32'h40);
    tick();
    look(32'h104, 1, 32'h40, 12, 8);

    // counter saturation: repeated mispredicted jumps (4-bit counters)
    for (int i = 0; i < 5; i++) begin
      jmp(3'b000, 32'h600, 32'h700, 0, 32'h604);
      chk(S_FL, 1);
      tick();
    end
    look(32'h104, 1, 32'h40, 15, 13);

    // reset in the same cycle as a mispredicting resolve
    br(3'b111, 32'h104, 32'h40, 1, 32'h40, 1, 0);
    reset = 1'b1;
    chk(S_FL, 0);
    tick();
    reset = 1'b0;
    look(32'h104, 0, 32'h108, 0, 0);
    look(32'h600, 0, 32'h604, 0, 0);

    idle(32'h0);
    tick();
    tick();
    if (exp_q.size() != 0) begin
      $display("FAIL scoreboard_drain left=%0d want=0", exp_q.size());
      bad += exp_q.size();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
